// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM state encoding and op classification for alu_multicycle
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_DIVU = 4'b1100;
    localparam logic [3:0] ALU_REMU = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Without the divider, DIVU/REMU decode as reserved single-cycle ops.
    function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_DIV_EN
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
`else
        return (op == ALU_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - one-bit-per-cycle shift-add multiplier and restoring divider
// Divider datapath present only when ALU_DIV_EN is defined.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CTRL_WIDTH-1:0] op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  divzero
);

    localparam int              CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH);

    logic                  busy_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CTRL_WIDTH-1:0] op_q;
    logic [DATA_WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic [DATA_WIDTH-1:0] hi_s, lo_s, opnd_s;
    logic [DATA_WIDTH-1:0] hi_d, lo_d, opnd_d;
    logic                  is_mul;

`ifdef ALU_DIV_EN
    logic [DATA_WIDTH:0] rem_sh, trial;
    logic                divzero_q;
`endif

    assign done   = busy_q && (cnt_q == LAST);
    assign is_mul = start ? (op == ALU_MUL) : (op_q == ALU_MUL);

    // The first step is applied on the start edge itself, so the unit is busy exactly DATA_WIDTH cycles.
    always_comb begin
        hi_s   = hi_q;
        lo_s   = lo_q;
        opnd_s = opnd_q;
        if (start) begin
            hi_s   = '0;
            lo_s   = is_mul ? b : a;
            opnd_s = is_mul ? a : b;
        end
    end

`ifdef ALU_DIV_EN
    assign rem_sh = {hi_s, lo_s[DATA_WIDTH-1]};
    assign trial  = rem_sh - {1'b0, opnd_s};
`endif

    // hi: accumulator / partial remainder, lo: multiplier / dividend-quotient, opnd: multiplicand / divisor.
    always_comb begin
        hi_d   = hi_s + (lo_s[0] ? opnd_s : '0);
        lo_d   = lo_s >> 1;
        opnd_d = opnd_s << 1;
`ifdef ALU_DIV_EN
        if (!is_mul) begin
            opnd_d = opnd_s;
            if (trial[DATA_WIDTH]) begin
                hi_d = rem_sh[DATA_WIDTH-1:0];
                lo_d = {lo_s[DATA_WIDTH-2:0], 1'b0};
            end else begin
                hi_d = trial[DATA_WIDTH-1:0];
                lo_d = {lo_s[DATA_WIDTH-2:0], 1'b1};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else if (start || (busy_q && !done)) begin
            busy_q <= 1'b1;
            cnt_q  <= start ? CNT_W'(1) : cnt_q + 1'b1;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            if (start) begin
                op_q <= op;
            end
        end else if (done) begin
            busy_q <= 1'b0;
        end
    end

`ifdef ALU_DIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divzero_q <= 1'b0;
        end else if (start) begin
            divzero_q <= (op != ALU_MUL) && (b == '0);
        end
    end

    assign result  = (op_q == ALU_DIVU) ? lo_q : hi_q;
    assign divzero = divzero_q;
`else
    assign result  = (op_q == ALU_MUL) ? hi_q : '0;
    assign divzero = 1'b0;
`endif

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - MIPS ALU with valid/ready handshake and iterative MUL/DIVU/REMU
// Define ALU_DIV_EN to build the divider; otherwise DIVU/REMU decode as reserved.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CTRL_WIDTH  = 4,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic [CTRL_WIDTH-1:0] ALUControl,
    input  logic                  InValid,
    output logic                  InReady,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  ZERO,
    output logic                  Overflow,
    output logic                  DivZero,
    output logic                  OutValid,
    input  logic                  OutReady
);

    localparam int MSB = DATA_WIDTH - 1;

    state_t                 state_q, state_d;
    logic                   accept, start;
    logic                   iter_done, iter_divzero;
    logic [DATA_WIDTH-1:0]  iter_result;
    logic [DATA_WIDTH-1:0]  sum, diff, sc_res;
    logic                   sc_ovf;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0]  res_q;
    logic                   zero_q, ovf_q, dz_q;

    assign sum   = SrcA + SrcB;
    assign diff  = SrcA - SrcB;
    assign shamt = SrcB[SHAMT_WIDTH-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        InReady  = 1'b0;
        OutValid = 1'b0;
        accept   = 1'b0;
        start    = 1'b0;
        case (state_q)
            IDLE: begin
                InReady = 1'b1;
                if (InValid) begin
                    accept = 1'b1;
                    if (is_multicycle(ALUControl)) begin
                        start   = 1'b1;
                        state_d = ITER;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ITER: begin
                if (iter_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                OutValid = 1'b1;
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reserved codes (and MUL, which never reaches here) fall to the zero default.
    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (ALUControl)
            ALU_AND:  sc_res = SrcA & SrcB;
            ALU_OR:   sc_res = SrcA | SrcB;
            ALU_XOR:  sc_res = SrcA ^ SrcB;
            ALU_NOR:  sc_res = ~(SrcA | SrcB);
            ALU_ADD: begin
                sc_res = sum;
                sc_ovf = (SrcA[MSB] == SrcB[MSB]) && (sum[MSB] != SrcA[MSB]);
            end
            ALU_SUB: begin
                sc_res = diff;
                sc_ovf = (SrcA[MSB] != SrcB[MSB]) && (diff[MSB] != SrcA[MSB]);
            end
            ALU_SLT:  sc_res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
            ALU_SLTU: sc_res = DATA_WIDTH'(SrcA < SrcB);
            ALU_SLL:  sc_res = SrcA << shamt;
            ALU_SRL:  sc_res = SrcA >> shamt;
            ALU_SRA:  sc_res = $signed(SrcA) >>> shamt;
            default:  sc_res = '0;
        endcase
    end

    alu_iter_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_iter (
        .clk     (CLK),
        .rst_n   (RST_N),
        .start   (start),
        .op      (ALUControl),
        .a       (SrcA),
        .b       (SrcB),
        .done    (iter_done),
        .result  (iter_result),
        .divzero (iter_divzero)
    );

    // Result and flags are only written on accept or iteration end, so they hold through DONE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            dz_q   <= 1'b0;
        end else if (accept && !start) begin
            res_q  <= sc_res;
            zero_q <= (sc_res == '0);
            ovf_q  <= sc_ovf;
            dz_q   <= 1'b0;
        end else if ((state_q == ITER) && iter_done) begin
            res_q  <= iter_result;
            zero_q <= (iter_result == '0);
            ovf_q  <= 1'b0;
            dz_q   <= iter_divzero;
        end
    end

    assign ALUResult = res_q;
    assign ZERO      = zero_q;
    assign Overflow  = ovf_q;
    assign DivZero   = dz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - randomized self-checking bench for alu_multicycle against an arithmetic model
module tb_alu_multicycle;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic [3:0]   ALUControl = '0;
    logic         InValid = 1'b0;
    logic         OutReady = 1'b0;
    logic         InReady, ZERO, Overflow, DivZero, OutValid;
    logic [W-1:0] ALUResult;

    int n_cmp = 0;
    int n_err = 0;

    alu_multicycle #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .InValid    (InValid),
        .InReady    (InReady),
        .ALUResult  (ALUResult),
        .ZERO       (ZERO),
        .Overflow   (Overflow),
        .DivZero    (DivZero),
        .OutValid   (OutValid),
        .OutReady   (OutReady)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic; overflow is "wrapped result differs from the true sum".
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ovf, output logic dz, output int lat);
        longint       s;
        logic [63:0]  p;
        r = '0; ovf = 1'b0; dz = 1'b0; lat = 1;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin r = a + b; s = longint'($signed(a)) + longint'($signed(b)); ovf = (s != longint'($signed(r))); end
            4'd3:  r = a ^ b;
            4'd4:  begin r = a - b; s = longint'($signed(a)) - longint'($signed(b)); ovf = (s != longint'($signed(r))); end
            4'd5:  begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; lat = W + 1; end
            4'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  r = ~(a | b);
            4'd8:  r = (a < b) ? 32'd1 : 32'd0;
            4'd9:  r = a << b[4:0];
            4'd10: r = a >> b[4:0];
            4'd11: r = $signed(a) >>> b[4:0];
`ifdef ALU_DIV_EN
            4'd12: begin lat = W + 1; dz = (b == 0); r = (b == 0) ? 32'hFFFF_FFFF : a / b; end
            4'd13: begin lat = W + 1; dz = (b == 0); r = (b == 0) ? a : a % b; end
`endif
            default: r = '0;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic        eo, ed;
        int          el, lat;
        model(op, a, b, er, eo, ed, el);
        @(negedge CLK);
        check("in_ready_idle", InReady, 1'b1);
        SrcA = a; SrcB = b; ALUControl = op; InValid = 1'b1;
        @(posedge CLK); #1;
        InValid = 1'b0;
        lat = 1;
        while (!OutValid && lat < 200) begin
            check("in_ready_busy", InReady, 1'b0);
            SrcA = $urandom; SrcB = $urandom; ALUControl = 4'($urandom); InValid = 1'($urandom);
            @(posedge CLK); #1;
            lat++;
        end
        InValid = 1'b0;
        check($sformatf("latency op%0d", op), lat, el);
        check($sformatf("result op%0d a=%h b=%h", op, a, b), ALUResult, er);
        check($sformatf("zero op%0d", op), ZERO, (er == 0));
        check($sformatf("overflow op%0d", op), Overflow, eo);
        check($sformatf("divzero op%0d", op), DivZero, ed);
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            check("hold_valid", OutValid, 1'b1);
            check("hold_in_ready", InReady, 1'b0);
            check("hold_result", ALUResult, er);
            check("hold_flags", {ZERO, Overflow, DivZero}, {(er == 0), eo, ed});
        end
        @(negedge CLK);
        OutReady = 1'b1;
        @(posedge CLK); #1;
        OutReady = 1'b0;
        check("release_valid", OutValid, 1'b0);
        check("release_in_ready", InReady, 1'b1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;

        RST_N = 1'b0;
        #12;
        check("reset_in_ready", InReady, 1'b1);
        check("reset_out_valid", OutValid, 1'b0);
        check("reset_result", ALUResult, 0);
        check("reset_flags", {ZERO, Overflow, DivZero}, 3'b000);
        @(negedge CLK);
        RST_N = 1'b1;

        // Abort a multiply in flight with an asynchronous reset.
        @(negedge CLK);
        SrcA = 32'h0001_0000; SrcB = 32'h0001_0001; ALUControl = 4'd5; InValid = 1'b1;
        @(posedge CLK); #1;
        InValid = 1'b0;
        repeat (10) @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check("midrst_in_ready", InReady, 1'b1);
        check("midrst_out_valid", OutValid, 1'b0);
        check("midrst_result", ALUResult, 0);
        check("midrst_flags", {ZERO, Overflow, DivZero}, 3'b000);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("postrst_out_valid", OutValid, 1'b0);

        run_op(4'd2, 32'd5, 32'd7, 0);
        run_op(4'd2, 32'h7FFF_FFFF, 32'd1, 0);
        run_op(4'd4, 32'd9, 32'd9, 0);
        run_op(4'd6, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'd8, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'd11, 32'h8000_0000, 32'h21, 0);
        run_op(4'd5, 32'h0001_0000, 32'h0001_0001, 0);
        run_op(4'd12, 32'd100, 32'd7, 0);
        run_op(4'd13, 32'd100, 32'd7, 0);
        run_op(4'd12, 32'd5, 32'd0, 0);
        run_op(4'd13, 32'd5, 32'd0, 0);
        run_op(4'd14, 32'd123, 32'd45, 0);
        run_op(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(4'd4, 32'h8000_0000, 32'd1, 5);
        run_op(4'd5, 32'hDEAD_BEEF, 32'h1234_5678, 5);

        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'h7FFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            run_op(op, a, b, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
